// File: rtl/skp_elastic_fifo.sv
// skp_elastic_fifo -- single-clock elastic buffer for SKP ordered-set rate matching.
//
// Symbols are written on in_vld (no backpressure) and read first-word-fall-through.
// When the buffer runs high, an incoming COM,SKP pair is swallowed: the COM is
// retracted from the buffer and the SKP is never written. When it runs low, a
// COM,SKP pair is replayed on the output after an outgoing SKP, and the read
// pointer is held meanwhile.
//
// Optional build macro: SKP_EFIFO_STATS_EN -- builds the saturating add/del/ovf
// statistics counters. Without it the three counter ports are tied to zero.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   in_data, in_vld          input symbol and strobe
//   out_data, out_vld,
//   out_rdy                  FWFT output symbol, valid, consumer ready
//   level, full, empty       occupancy status
//   skp_added, skp_deleted,
//   overflow                 one-cycle event pulses (cycle after the event edge)
//   add_cnt, del_cnt,
//   ovf_cnt                  16-bit saturating event counters
module skp_elastic_fifo #(
  parameter int                DATA_W   = 10,
  parameter int                DEPTH    = 16,
  parameter int                ADD_TH   = 6,
  parameter int                DEL_TH   = 10,
  parameter logic [DATA_W-1:0] SKP_SYM1 = DATA_W'(10'h0f9),
  parameter logic [DATA_W-1:0] SKP_SYM2 = DATA_W'(10'h306)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_vld,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      empty,
  output logic                      skp_added,
  output logic                      skp_deleted,
  output logic                      overflow,
  output logic [15:0]               add_cnt,
  output logic [15:0]               del_cnt,
  output logic [15:0]               ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
  localparam logic [PW-1:0] ADD_TH_L = PW'(ADD_TH);
  localparam logic [PW-1:0] DEL_TH_L = PW'(DEL_TH);

  typedef enum logic [1:0] {
    IDLE,
    INS1,
    INS2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              in_skp1;
  logic              out_skp1;

  logic              del_hit;
  logic              wr_en;
  logic              ovf_hit;
  logic              xfer;
  logic              ins_start;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);

  // Deletion wins over both write and overflow: nothing is stored, so a full
  // buffer does not prevent retracting the COM.
  assign del_hit = in_vld && (in_data == SKP_SYM2) && in_skp1 && (level > DEL_TH_L);
  assign wr_en   = in_vld && !full && !del_hit;
  assign ovf_hit = in_vld && full && !del_hit;

  always_comb begin
    out_vld  = 1'b0;
    out_data = mem[rd_ptr[AW-1:0]];
    case (state)
      IDLE: begin
        out_vld  = !empty;
        out_data = mem[rd_ptr[AW-1:0]];
      end
      INS1: begin
        out_vld  = 1'b1;
        out_data = SKP_SYM1;
      end
      INS2: begin
        out_vld  = 1'b1;
        out_data = SKP_SYM2;
      end
      default: begin
        out_vld  = 1'b0;
        out_data = mem[rd_ptr[AW-1:0]];
      end
    endcase
  end

  assign xfer = out_vld && out_rdy;

  // Post-read level (level-1) below ADD_TH; level >= 1 whenever a transfer
  // happens in IDLE, so this is the same as level <= ADD_TH.
  assign ins_start = (state == IDLE) && xfer && (out_data == SKP_SYM2) &&
                     out_skp1 && (level <= ADD_TH_L);

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      in_skp1     <= 1'b0;
      out_skp1    <= 1'b0;
      state       <= IDLE;
      skp_added   <= 1'b0;
      skp_deleted <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      skp_added   <= ins_start;
      skp_deleted <= del_hit;
      overflow    <= ovf_hit;

      // Retraction steps wr_ptr back over the COM written last cycle(s); with
      // level > DEL_TH that entry cannot be the one being read this cycle.
      if (del_hit) begin
        wr_ptr  <= wr_ptr - PW'(1);
        in_skp1 <= 1'b0;
      end else if (wr_en) begin
        wr_ptr  <= wr_ptr + PW'(1);
        in_skp1 <= (in_data == SKP_SYM1);
      end

      if (xfer) begin
        out_skp1 <= (out_data == SKP_SYM1);
      end

      case (state)
        IDLE: begin
          if (xfer) begin
            rd_ptr <= rd_ptr + PW'(1);
          end
          if (ins_start) begin
            state <= INS1;
          end
        end
        INS1: begin
          if (out_rdy) begin
            state <= INS2;
          end
        end
        INS2: begin
          if (out_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SKP_EFIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      add_cnt <= '0;
      del_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      if (ins_start && (add_cnt != '1)) begin
        add_cnt <= add_cnt + 16'd1;
      end
      if (del_hit && (del_cnt != '1)) begin
        del_cnt <= del_cnt + 16'd1;
      end
      if (ovf_hit && (ovf_cnt != '1)) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end
`else
  assign add_cnt = '0;
  assign del_cnt = '0;
  assign ovf_cnt = '0;
`endif

endmodule
